stopwatch_key_ctrl: RTL
=======================

# stopwatch_key_ctrl

Parametrised stopwatch control front end: synchronises, debounces and edge-detects three raw push-button inputs (start, pause, load). A four-state FSM converts the key events into count-enable, clear and preset-load controls for the watch counter chain. Adds pause, long-press clear, debounce and a state output for display logic. Sits between the board buttons and the watch counter.

## Interface

- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a key level is accepted; 10 ms at 50 MHz.
- LONG_PRESS_CYCLES, 100000000: debounced start-key hold length that forces a clear; must be greater than DEBOUNCE_CYCLES.
- KEY_ACTIVE_LOW, 1: 1 means a raw key reads 0 when pressed.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_start  input  1  raw start/stop/reset button; asynchronous to clk.
- key_pause  input  1  raw pause/resume button; asynchronous to clk.
- key_load  input  1  raw preset-load button; asynchronous to clk.
- cnt_en  output  1  counter count enable; level signal.
- cnt_clr  output  1  counter synchronous clear; one-cycle pulse.
- cnt_load  output  1  counter preset load; one-cycle pulse.
- state  output  2  current FSM state, for display logic.

## Operation

**Key path (per key)**
- 2-FF synchroniser.
- Polarity normalisation, so that 1 = pressed.
- Debounce: a counter increments while the synchronised value differs from the debounced level. It resets to 0 on any equality. When it reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter resets.
- Press event: a one-cycle pulse on the 0→1 transition of the debounced level. Release produces no event.

**Long press (start key only)**
- A hold counter runs while the debounced start level is 1, and saturates.
- When it reaches LONG_PRESS_CYCLES, one long event fires.
- The hold counter clears on release.

**FSM states**
- IDLE=2'd0: cleared, cnt_en=0.
- RUN=2'd1: cnt_en=1.
- PAUSE=2'd2: cnt_en=0.
- STOP=2'd3: cnt_en=0, value frozen.

**Transitions**
- start: IDLE→RUN; RUN→STOP; PAUSE→STOP; STOP→IDLE with a cnt_clr pulse.
- pause: RUN→PAUSE; PAUSE→RUN; ignored in IDLE and STOP.
- load: IDLE→IDLE or STOP→IDLE, with a cnt_load pulse; ignored in RUN and PAUSE.
- long: any state→IDLE with a cnt_clr pulse. The start press edge that began the hold has already acted; the later release does nothing.

**Rules**
- Simultaneous events in one cycle: priority is long > start > pause > load. Only the winner acts; the others are discarded, not queued.
- cnt_clr and cnt_load are never asserted in the same cycle.
- All outputs are registered.

## Timing

- Reset values: state=IDLE, cnt_en=0, cnt_clr=0, cnt_load=0. Debounced levels are "released", and all counters are 0.
- Latency: a raw key change held stable from edge k gives an output/state change at edge k+DEBOUNCE_CYCLES+3. This is 2 sync stages + debounce + 1 FSM register.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- cnt_en changes on the same edge as state.
- Pulses last exactly one clk cycle.
- Long event: the FSM acts LONG_PRESS_CYCLES+1 cycles after the debounced start rise.
- Reset asserted mid-debounce or mid-hold: everything returns to reset values immediately. A key still held after reset release is seen as a new press once debounced.
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) and $clog2(LONG_PRESS_CYCLES+1). Counters never wrap.

## Structure

- Shared package stopwatch_pkg holds the state encodings (IDLE/RUN/PAUSE/STOP) and the state width. Display logic reuses them.
- Sub-module key_debounce, parameterised by DEBOUNCE_CYCLES and KEY_ACTIVE_LOW. It contains the synchroniser, debounce and press-pulse logic, and is instantiated three times.
- Long-press counter and FSM live in the top module.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=32, KEY_ACTIVE_LOW=0.

- **Reset:** hold rst with keys idle → state=0, cnt_en=0, no pulses. Assert rst asynchronously mid-RUN → cnt_en=0 before the next clk edge.
- **Bounce:** start toggles with 2-cycle pulses for 20 cycles, then holds → exactly one IDLE→RUN. cnt_en rises 7 cycles after the stable hold begins.
- **Full cycle:** start, pause, pause, start, start → states 1,2,1,3,0. Exactly one cnt_clr pulse occurs, on entry to IDLE.
- **Load:** load in RUN → ignored. load in STOP → one cnt_load pulse and state=0.
- **Long press:** from RUN, hold start for 60 cycles → state 3 at the press edge. Then state 0 with one cnt_clr pulse, 33 cycles after the debounced rise. Release → no change.
- **Simultaneous:** start and pause pressed on the same cycle from IDLE → state=1 only, no PAUSE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: controller state encodings, reused by the display logic.
package stopwatch_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button path: 2-FF synchroniser, polarity normalisation, counter debounce
// and a one-cycle press pulse on the debounced 0->1 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_q1;
    logic             sync_q2;
    logic             key_now;
    logic [CNT_W-1:0] cnt_q;

    // Synchroniser flops reset to the raw "released" level so reset release never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= KEY_ACTIVE_LOW;
            sync_q2 <= KEY_ACTIVE_LOW;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign key_now = sync_q2 ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= key_now && !level && (cnt_q == CNT_MAX);
            if (key_now == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level <= key_now;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_key_ctrl.sv
// Stopwatch control front end: three debounced keys plus a start-key long press drive
// a four-state FSM producing registered count-enable, clear and preset-load controls.
module stopwatch_key_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 100000000,
    parameter bit KEY_ACTIVE_LOW    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_start,
    input  logic               key_pause,
    input  logic               key_load,
    output logic               cnt_en,
    output logic               cnt_clr,
    output logic               cnt_load,
    output logic [STATE_W-1:0] state
);

    localparam int                HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic start_level, pause_level, load_level;
    logic start_press, pause_press, load_press;
    logic [1:0] unused_levels;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)) u_start (
        .clk(clk), .rst(rst), .key_raw(key_start), .level(start_level), .press(start_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)) u_pause (
        .clk(clk), .rst(rst), .key_raw(key_pause), .level(pause_level), .press(pause_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)) u_load (
        .clk(clk), .rst(rst), .key_raw(key_load), .level(load_level), .press(load_press)
    );

    // Only the start key has a hold function; the other levels are deliberately dropped.
    assign unused_levels = {pause_level, load_level};

    logic [HOLD_W-1:0] hold_q;
    logic              long_evt;

    // Saturating hold counter; the long event fires once, on the cycle the count reaches its limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q   <= '0;
            long_evt <= 1'b0;
        end else begin
            long_evt <= start_level && (hold_q == HOLD_LAST);
            if (!start_level) begin
                hold_q <= '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    state_e state_q, state_d;
    logic   en_d, clr_d, load_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_load <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_en   <= en_d;
            cnt_clr  <= clr_d;
            cnt_load <= load_d;
        end
    end

    // Strict event priority: long > start > pause > load; losing events are dropped.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        clr_d   = 1'b0;
        load_d  = 1'b0;
        if (long_evt) begin
            state_d = IDLE;
            clr_d   = 1'b1;
        end else if (start_press) begin
            unique case (state_q)
                IDLE:       state_d = RUN;
                RUN, PAUSE: state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            endcase
        end else if (pause_press) begin
            case (state_q)
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = state_q;
            endcase
        end else if (load_press) begin
            if (state_q == IDLE || state_q == STOP) begin
                state_d = IDLE;
                load_d  = 1'b1;
            end
        end
        en_d = (state_d == RUN);
    end

    assign state = state_q;

endmodule
